// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: owns the PC and streams ROM words to decode
// through a one-entry valid/ready output register.
module instruction_fetch_sequencer #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_instruction,
  input  logic              rom_mem_end,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_address,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic slot_free, xfer;
  assign slot_free = !instr_valid || instr_ready;
  assign xfer = instr_valid && instr_ready;
  assign rom_address = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= START_ADDR;
      instr_valid <= 1'b0;
      instr_data <= '0;
      instr_pc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          pc <= START_ADDR;
          state <= RUN;
          busy <= 1'b1;
          done <= 1'b0;
        end
        RUN: if (redirect_valid) begin
          pc <= redirect_address;
          instr_valid <= 1'b0;
        end else if (rom_mem_end) begin
          if (xfer) instr_valid <= 1'b0;
          state <= DRAIN;
        end else if (slot_free) begin
          instr_data <= rom_instruction;
          instr_pc <= pc;
          instr_valid <= 1'b1;
          pc <= pc + ADDR_W'(1);
        end
        DRAIN: if (redirect_valid) begin
          pc <= redirect_address;
          instr_valid <= 1'b0;
          state <= RUN;
        end else if (!instr_valid || xfer) begin
          instr_valid <= 1'b0;
          state <= HALT;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: directed program walk plus random traffic
// checked against a slot-queue reference model.
module tb_instruction_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, redirect_valid, instr_ready;
  logic [29:0] redirect_address, rom_address, instr_pc;
  logic [31:0] rom_instruction, instr_data;
  logic rom_mem_end, instr_valid, busy, done;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // Program occupies 0..33; the top 16 addresses are also code so PC wrap can be exercised.
  function automatic logic [31:0] rom_word(input logic [29:0] a);
    if (a == 30'd33) return 32'h0000_1820;
    if (a < 30'd33) return {8'h04, a[7:0], 16'(a + 30'd1)};
    return {2'b10, a};
  endfunction
  function automatic logic rom_end(input logic [29:0] a);
    return a >= 30'd34 && a < 30'h3FFF_FFF0;
  endfunction

  assign rom_instruction = rom_word(rom_address);
  assign rom_mem_end = rom_end(rom_address);

  instruction_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_address(rom_address),
    .rom_instruction(rom_instruction), .rom_mem_end(rom_mem_end),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .busy(busy), .done(done)
  );

  typedef struct packed {logic [29:0] pc; logic [31:0] d;} ent_t;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_HALT = 3;
  ent_t slot[$];
  int phase;
  logic [29:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    m_pc = '0;
    slot.delete();
  endtask

  task automatic model_step();
    bit xfer;
    xfer = slot.size() != 0 && instr_ready;
    if (phase == P_IDLE || phase == P_HALT) begin
      if (start) begin m_pc = '0; phase = P_RUN; end
    end else if (phase == P_RUN) begin
      if (redirect_valid) begin m_pc = redirect_address; slot.delete(); end
      else if (rom_end(m_pc)) begin if (xfer) slot.delete(); phase = P_DRAIN; end
      else if (slot.size() == 0 || instr_ready) begin
        slot.delete();
        slot.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 30'd1;
      end
    end else begin
      if (redirect_valid) begin m_pc = redirect_address; slot.delete(); phase = P_RUN; end
      else if (slot.size() == 0 || xfer) begin slot.delete(); phase = P_HALT; end
    end
  endtask

  task automatic cyc(input logic s, input logic r, input logic rv, input logic [29:0] ra);
    start = s;
    instr_ready = r;
    redirect_valid = rv;
    redirect_address = ra;
    model_step();
    @(negedge clk);
    chk("m_valid", instr_valid, slot.size() != 0);
    chk("m_busy", busy, phase == P_RUN || phase == P_DRAIN);
    chk("m_done", done, phase == P_HALT);
    chk("m_rom_address", rom_address, m_pc);
    if (slot.size() != 0) begin
      chk("m_pc", instr_pc, slot[0].pc);
      chk("m_data", instr_data, slot[0].d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_address = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_address", rom_address, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    cyc(1'b1, 1'b1, 1'b0, 30'd0);
    chk("lat_n1_valid", instr_valid, 0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("lat_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 0);
    chk("first_data", instr_data, 32'h0400_0001);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("second_pc", instr_pc, 1);
    chk("second_data", instr_data, 32'h0401_0002);
    for (int i = 2; i < 34; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 30'd0);
      chk("seq_pc", instr_pc, 64'(i));
    end
    chk("last_data", instr_data, 32'h0000_1820);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("drain_valid", instr_valid, 0);
    chk("drain_busy", busy, 1);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    repeat (3) begin
      cyc(1'b0, 1'b1, 1'b1, 30'd5);
      chk("halt_no_valid", instr_valid, 0);
      chk("halt_rom_address", rom_address, 34);
    end
    cyc(1'b1, 1'b1, 1'b0, 30'd0);
    chk("restart_done", done, 0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("restart_pc", instr_pc, 0);
    chk("restart_data", instr_data, 32'h0400_0001);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("bp_pc_before", instr_pc, 2);
    repeat (5) begin
      cyc(1'b0, 1'b0, 1'b0, 30'd0);
      chk("bp_data", instr_data, 32'h0402_0003);
      chk("bp_pc", instr_pc, 2);
      chk("bp_rom_address", rom_address, 3);
    end
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("bp_release_pc", instr_pc, 3);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("pre_redirect_pc", instr_pc, 5);
    cyc(1'b0, 1'b1, 1'b1, 30'd30);
    chk("redirect_flush", instr_valid, 0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("redirect_pc", instr_pc, 30);
    chk("redirect_data", instr_data, 32'h041E_001F);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 30'd0);
    cyc(1'b0, 1'b0, 1'b0, 30'd0);
    chk("drain_hold_valid", instr_valid, 1);
    chk("drain_hold_pc", instr_pc, 33);
    cyc(1'b0, 1'b0, 1'b1, 30'd10);
    chk("drain_redirect_flush", instr_valid, 0);
    chk("drain_redirect_busy", busy, 1);
    cyc(1'b0, 1'b1, 1'b0, 30'd0);
    chk("drain_redirect_pc", instr_pc, 10);
    cyc(1'b0, 1'b0, 1'b0, 30'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_data", instr_data, 0);
    chk("async_pc", instr_pc, 0);
    chk("async_busy", busy, 0);
    chk("async_rom_address", rom_address, 0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) begin
      cyc(1'b0, 1'b1, 1'b0, 30'd0);
      chk("post_reset_idle", busy, 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 30'd0);
    for (int i = 0; i < 3000; i++) begin
      logic [29:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFC + 30'($urandom_range(0, 3))
                                       : 30'($urandom_range(0, 40));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, ra);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
